// File: rtl/emu_stop_ctrl.sv
// Failure/stop sequencer: captures the first unmasked failing source with a
// timestamp, waits out a drain window, then runs a stop_req/stop_ack handshake.
module emu_stop_ctrl #(
  parameter  int NSRC      = 4,
  parameter  int TS_W      = 32,
  parameter  int DRAIN_CYC = 8,
  localparam int ID_W      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [NSRC-1:0] src_fail,
  input  logic [NSRC-1:0] src_mask,
  input  logic            clear,
  input  logic            stop_ack,
  output logic            stop_req,
  output logic            failure,
  output logic [ID_W-1:0] fail_id,
  output logic            fail_multi,
  output logic [TS_W-1:0] fail_time,
  output logic [1:0]      state
);

  localparam int DC_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_STOP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            stop_req_q, stop_req_d;
  logic            failure_q, failure_d;
  logic [ID_W-1:0] fail_id_q, fail_id_d;
  logic            fail_multi_q, fail_multi_d;
  logic [TS_W-1:0] fail_time_q, fail_time_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [DC_W-1:0] drain_q, drain_d;

  logic [NSRC-1:0] act;
  logic            act_any;
  logic            act_multi;
  logic [ID_W-1:0] low_id;

  assign act       = src_fail & ~src_mask;
  assign act_any   = |act;
  // clearing the lowest set bit leaves something only if two or more were set
  assign act_multi = |(act & (act - NSRC'(1)));

  always_comb begin
    low_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) low_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    stop_req_d   = stop_req_q;
    failure_d    = failure_q;
    fail_id_d    = fail_id_q;
    fail_multi_d = fail_multi_q;
    fail_time_d  = fail_time_q;
    drain_d      = drain_q;
    ts_d         = ts_q + TS_W'(1);

    case (state_q)
      S_IDLE: begin
        if (enable && act_any) begin
          failure_d    = 1'b1;
          fail_id_d    = low_id;
          fail_time_d  = ts_q;
          fail_multi_d = act_multi;
          if (DRAIN_CYC > 0) begin
            state_d = S_DRAIN;
            drain_d = DC_W'(DRAIN_CYC);
          end else begin
            state_d    = S_STOP;
            stop_req_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (act_any) fail_multi_d = 1'b1;
        if (drain_q <= DC_W'(1)) begin
          drain_d    = '0;
          state_d    = S_STOP;
          stop_req_d = 1'b1;
        end else begin
          drain_d = drain_q - DC_W'(1);
        end
      end
      S_STOP: begin
        if (act_any) fail_multi_d = 1'b1;
        stop_req_d = 1'b1;
        if (stop_ack) begin
          stop_req_d = 1'b0;
          state_d    = S_HALTED;
        end
      end
      S_HALTED: begin
        stop_req_d = 1'b0;
        if (act_any) fail_multi_d = 1'b1;
        // fail_id/fail_time stay visible until the next capture overwrites them
        if (clear) begin
          state_d      = S_IDLE;
          failure_d    = 1'b0;
          fail_multi_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        stop_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stop_req_q   <= 1'b0;
      failure_q    <= 1'b0;
      fail_id_q    <= '0;
      fail_multi_q <= 1'b0;
      fail_time_q  <= '0;
      ts_q         <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      stop_req_q   <= stop_req_d;
      failure_q    <= failure_d;
      fail_id_q    <= fail_id_d;
      fail_multi_q <= fail_multi_d;
      fail_time_q  <= fail_time_d;
      ts_q         <= ts_d;
      drain_q      <= drain_d;
    end
  end

  assign stop_req   = stop_req_q;
  assign failure    = failure_q;
  assign fail_id    = fail_id_q;
  assign fail_multi = fail_multi_q;
  assign fail_time  = fail_time_q;
  assign state      = state_q;

endmodule

// File: tb/tb_emu_stop_ctrl.sv
// Bench for emu_stop_ctrl: capture vectors on a DRAIN_CYC=8 instance, plus
// handshake, drain, reset, DRAIN_CYC=0 and timestamp-wrap sequences.
module tb_emu_stop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: NSRC=4, TS_W=32, DRAIN_CYC=8
  logic        a_rst, a_en, a_clear, a_ack;
  logic [3:0]  a_f, a_m;
  logic        a_stop_req, a_failure, a_multi;
  logic [1:0]  a_id, a_state;
  logic [31:0] a_time;

  // instance B: NSRC=4, TS_W=4, DRAIN_CYC=0
  logic        b_rst, b_en, b_clear, b_ack;
  logic [3:0]  b_f, b_m;
  logic        b_stop_req, b_failure, b_multi;
  logic [1:0]  b_id, b_state;
  logic [3:0]  b_time;
  logic [3:0]  ts2_m;

  emu_stop_ctrl #(.NSRC(4), .TS_W(32), .DRAIN_CYC(8)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .src_fail(a_f), .src_mask(a_m),
    .clear(a_clear), .stop_ack(a_ack), .stop_req(a_stop_req), .failure(a_failure),
    .fail_id(a_id), .fail_multi(a_multi), .fail_time(a_time), .state(a_state)
  );

  emu_stop_ctrl #(.NSRC(4), .TS_W(4), .DRAIN_CYC(0)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .src_fail(b_f), .src_mask(b_m),
    .clear(b_clear), .stop_ack(b_ack), .stop_req(b_stop_req), .failure(b_failure),
    .fail_id(b_id), .fail_multi(b_multi), .fail_time(b_time), .state(b_state)
  );

  always @(posedge clk or posedge b_rst) begin
    if (b_rst) ts2_m <= 4'd0;
    else       ts2_m <= ts2_m + 4'd1;
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else passed++;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] f;
    logic [3:0] m;
    logic       exp_fail;
    logic [1:0] exp_id;
    logic       exp_multi;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[8];

  task automatic reset_a();
    @(negedge clk);
    a_rst = 1'b1; a_en = 1'b0; a_f = 4'd0; a_m = 4'd0; a_clear = 1'b0; a_ack = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    @(negedge clk);
    b_rst = 1'b1; b_en = 1'b0; b_f = 4'd0; b_m = 4'd0; b_clear = 1'b0; b_ack = 1'b0;
    @(negedge clk);
    b_rst = 1'b0;
  endtask

  initial begin
    int cyc;
    logic ok;

    a_rst = 1'b1; a_en = 1'b0; a_f = 4'd0; a_m = 4'd0; a_clear = 1'b0; a_ack = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_f = 4'd0; b_m = 4'd0; b_clear = 1'b0; b_ack = 1'b0;

    vecs[0] = '{1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd1};
    vecs[1] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[2] = '{1'b1, 4'b1010, 4'b0010, 1'b1, 2'd3, 1'b0, 2'd1};
    vecs[3] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 4'b0011, 4'b0011, 1'b0, 2'd0, 1'b0, 2'd0};
    vecs[5] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd1};
    vecs[6] = '{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd1, 1'b1, 2'd1};
    vecs[7] = '{1'b1, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd1};

    #1;
    chk("rst_state",    a_state,    0);
    chk("rst_stop_req", a_stop_req, 0);
    chk("rst_failure",  a_failure,  0);
    chk("rst_time",     a_time,     0);

    // capture table: each vector sampled in the first cycle after reset (timestamp 0)
    for (int i = 0; i < 8; i++) begin
      reset_a();
      a_en = vecs[i].en; a_f = vecs[i].f; a_m = vecs[i].m;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_failure", i), a_failure,  vecs[i].exp_fail);
      chk($sformatf("vec%0d_id", i),      a_id,       vecs[i].exp_id);
      chk($sformatf("vec%0d_multi", i),   a_multi,    vecs[i].exp_multi);
      chk($sformatf("vec%0d_state", i),   a_state,    vecs[i].exp_state);
      chk($sformatf("vec%0d_time", i),    a_time,     0);
      chk($sformatf("vec%0d_stop_req", i), a_stop_req, 0);
    end

    // single source at timestamp 100, drain latency, handshake, clear
    reset_a();
    repeat (100) @(posedge clk);
    @(negedge clk);
    a_en = 1'b1; a_f = 4'b0100;
    @(posedge clk); #1;
    chk("ts100_failure", a_failure, 1);
    chk("ts100_id",      a_id,      2);
    chk("ts100_time",    a_time,    100);
    @(negedge clk);
    a_f = 4'd0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!a_stop_req && cyc < 30);
    chk("drain_latency", cyc + 1, 9);
    chk("drain_state",   a_state, 2);
    chk("ts100_multi",   a_multi, 0);
    ok = 1'b1;
    repeat (20) begin @(posedge clk); #1; ok &= (a_stop_req === 1'b1) && (a_state === 2'd2); end
    chk("hold_stop_no_ack", ok, 1);
    @(negedge clk); a_ack = 1'b1;
    @(posedge clk); #1;
    chk("ack_stop_req", a_stop_req, 0);
    chk("ack_state",    a_state,    3);
    @(negedge clk); a_ack = 1'b0;
    @(posedge clk); #1;
    chk("halt_failure", a_failure, 1);
    chk("halt_time",    a_time,    100);
    @(negedge clk); a_clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_state",   a_state,   0);
    chk("clear_failure", a_failure, 0);
    chk("clear_keep_id", a_id,      2);
    chk("clear_keep_ts", a_time,    100);
    @(negedge clk); a_clear = 1'b0;

    // clear in DRAIN is ignored, then rst mid-STOP drops everything at once
    reset_a();
    repeat (5) @(posedge clk);
    @(negedge clk);
    a_en = 1'b1; a_f = 4'b1000;
    @(posedge clk); #1;
    chk("d2_time", a_time, 5);
    @(negedge clk); a_f = 4'd0; a_clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_in_drain_state",   a_state,   1);
    chk("clear_in_drain_failure", a_failure, 1);
    @(negedge clk); a_clear = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!a_stop_req && cyc < 30);
    chk("drain_after_clear_latency", cyc + 2, 9);
    @(negedge clk); #2;
    a_rst = 1'b1;
    #1;
    chk("async_rst_stop_req", a_stop_req, 0);
    chk("async_rst_state",    a_state,    0);
    chk("async_rst_failure",  a_failure,  0);
    chk("async_rst_id",       a_id,       0);
    chk("async_rst_time",     a_time,     0);
    @(negedge clk); a_rst = 1'b0;

    // DRAIN_CYC=0: enable gating, immediate stop, multi during STOP
    reset_b();
    b_en = 1'b0; b_f = 4'b0001;
    ok = 1'b1;
    repeat (3) begin @(posedge clk); #1; ok &= (b_failure === 1'b0) && (b_state === 2'd0); end
    chk("enable_low_no_capture", ok, 1);
    @(negedge clk); b_en = 1'b1;
    @(posedge clk); #1;
    chk("d0_stop_req", b_stop_req, 1);
    chk("d0_state",    b_state,    2);
    chk("d0_time",     b_time,     3);
    chk("d0_multi",    b_multi,    0);
    @(negedge clk); b_f = 4'd0;
    @(posedge clk); #1;
    chk("d0_multi_quiet", b_multi, 0);
    @(negedge clk); b_f = 4'b0100;
    @(posedge clk); #1;
    chk("stop_multi",   b_multi,    1);
    chk("stop_keep_id", b_id,       0);
    chk("stop_held",    b_stop_req, 1);
    @(negedge clk); b_f = 4'd0; b_ack = 1'b1;
    @(posedge clk); #1;
    chk("b_ack_state", b_state, 3);
    @(negedge clk); b_ack = 1'b0; b_clear = 1'b1;
    @(posedge clk); #1;
    chk("b_clear_state", b_state, 0);
    chk("b_clear_multi", b_multi, 0);
    @(negedge clk); b_clear = 1'b0;

    // timestamp wrap: capture at 15, then at 0 after the wrap
    cyc = 0;
    while (ts2_m != 4'd15 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("wait_ts15", cyc < 40, 1);
    b_f = 4'b0010;
    @(posedge clk); #1;
    chk("wrap_time15", b_time, 15);
    chk("wrap_id",     b_id,   1);
    @(negedge clk); b_f = 4'd0; b_ack = 1'b1;
    @(negedge clk); b_ack = 1'b0; b_clear = 1'b1;
    @(negedge clk); b_clear = 1'b0;
    cyc = 0;
    while (ts2_m != 4'd0 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("wait_ts0", cyc < 40, 1);
    b_f = 4'b0001;
    @(posedge clk); #1;
    chk("wrap_time0", b_time, 0);
    @(negedge clk); b_f = 4'd0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
